// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: control-bit positions, load/store
// funct3 encodings, FSM state type and the default bus timeout.
package riscv_pkg;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } mem_state_e;

endpackage

// File: rtl/load_align.sv
// Load data extraction: shifts the addressed byte/half down to bit 0 and
// sign- or zero-extends according to funct3. Purely combinational.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    case (funct3_i)
      F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  data_o = {24'h0, shifted[7:0]};
      F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  data_o = {16'h0, shifted[15:0]};
      default: data_o = shifted;  // word access is aligned, so no shift applies
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues data-bus requests, stalls upstream while the
// bus is busy, aborts after TIMEOUT wait cycles. States: S_IDLE | accept op,
// S_WAIT | request held, waiting for ack or timeout.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [4:0]  ex_reg_addr,
  input  logic [7:0]  ex_control,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  output logic [4:0]  f_mem_reg_addr,
  output logic [7:0]  f_mem_control,
  output logic [31:0] f_mem_memdata,
  output logic [31:0] f_mem_regdata,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_op, is_load, is_store, is_byte, is_half, misalign, done;
  logic [31:0]      load_data;

  assign mem_op   = ex_valid & (ex_control[CTRL_MEM_READ] | ex_control[CTRL_MEM_WRITE]);
  assign is_load  = mem_op & ex_control[CTRL_MEM_READ];
  assign is_store = mem_op & ~ex_control[CTRL_MEM_READ];
  // LBU/LHU encodings mean nothing for stores, which then fall back to SW.
  assign is_byte  = (ex_funct3 == F3_LB) | (is_load & (ex_funct3 == F3_LBU));
  assign is_half  = (ex_funct3 == F3_LH) | (is_load & (ex_funct3 == F3_LHU));
  assign misalign = mem_op & (is_half ? ex_alu_result[0]
                                      : (~is_byte & (ex_alu_result[1:0] != 2'b00)));

  load_align u_load_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (ex_alu_result[1:0]),
    .funct3_i  (ex_funct3),
    .data_o    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;
    dmem_req   = 1'b0;
    done       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            if (misalign) begin
              misalign_o = 1'b1;
            end else begin
              dmem_req = 1'b1;
              if (dmem_ack) begin
                done = 1'b1;
              end else begin
                stall_o = 1'b1;
                state_d = S_WAIT;
                cnt_d   = '0;
              end
            end
          end
        end
        S_WAIT: begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            dmem_req  = 1'b0;
            bus_err_o = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stall_o = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    f_mem_reg_addr = '0;
    f_mem_control  = '0;
    f_mem_memdata  = '0;
    f_mem_regdata  = '0;
    if (rst_n && !stall_o) begin
      f_mem_reg_addr = ex_reg_addr;
      f_mem_control  = ex_control;
      f_mem_regdata  = ex_alu_result;
      if (misalign_o || bus_err_o) f_mem_control[2:0] = 3'b000;
      if (done && is_load) f_mem_memdata = load_data;
    end
  end

  always_comb begin
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = 4'b0000;
    if (dmem_req) begin
      dmem_addr = {ex_alu_result[31:2], 2'b00};
      if (is_store) begin
        dmem_we = 1'b1;
        if (is_byte) begin
          dmem_be    = 4'b0001 << ex_alu_result[1:0];
          dmem_wdata = {4{ex_store_data[7:0]}};
        end else if (is_half) begin
          dmem_be    = 4'b0011 << ex_alu_result[1:0];
          dmem_wdata = {2{ex_store_data[15:0]}};
        end else begin
          dmem_be    = 4'b1111;
          dmem_wdata = ex_store_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected MEM/WB results are queued when an
// op is driven and compared when the stage stops stalling.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic        ex_valid;
  logic [4:0]  ex_reg_addr;
  logic [7:0]  ex_control;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [2:0]  ex_funct3;
  logic [4:0]  f_mem_reg_addr;
  logic [7:0]  f_mem_control;
  logic [31:0] f_mem_memdata, f_mem_regdata;
  logic        stall_o, misalign_o, bus_err_o;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  typedef struct {
    logic [4:0]  ra;
    logic [7:0]  ctrl;
    logic [31:0] md;
    logic [31:0] rgd;
    int          stalls;
    logic        mis;
    logic        berr;
    logic        req_done;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_reg_addr(ex_reg_addr), .ex_control(ex_control),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_funct3(ex_funct3),
    .f_mem_reg_addr(f_mem_reg_addr), .f_mem_control(f_mem_control),
    .f_mem_memdata(f_mem_memdata), .f_mem_regdata(f_mem_regdata),
    .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] lo,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic ref_mis(input logic ld, input logic [2:0] f3, input logic [1:0] lo);
    if (f3 == 3'b000 || (ld && f3 == 3'b100)) return 1'b0;
    if (f3 == 3'b001 || (ld && f3 == 3'b101)) return lo[0];
    return lo != 2'b00;
  endfunction

  // ackd: cycle index (0 = first cycle) at which ack is driven; -1 = never
  task automatic do_op(input string tag, input logic v, input logic [4:0] ra,
                       input logic [7:0] c, input logic [31:0] a, input logic [31:0] sd,
                       input logic [2:0] f3, input int ackd, input logic [31:0] rd);
    exp_t        e, got;
    logic        mem, ld, st, req0, done;
    logic [3:0]  be;
    logic [31:0] wd;
    int          nst;
    mem = v && (c[1] || c[2]);
    ld  = mem && c[1];
    st  = mem && !c[1];
    e.ra = ra;
    e.rgd = a;
    e.mis = mem && ref_mis(ld, f3, a[1:0]);
    req0 = mem && !e.mis;
    if (!req0) begin
      e.stalls = 0; e.berr = 1'b0; e.req_done = 1'b0;
    end else if (ackd >= 0 && ackd <= TO + 1) begin
      e.stalls = ackd; e.berr = 1'b0; e.req_done = 1'b1;
    end else begin
      e.stalls = TO + 1; e.berr = 1'b1; e.req_done = 1'b0;
    end
    e.ctrl = (e.mis || e.berr) ? (c & 8'hF8) : c;
    e.md   = (ld && req0 && !e.berr) ? ref_load(rd, a[1:0], f3) : 32'h0;
    be = 4'b0000;
    wd = 32'h0;
    if (st && req0) begin
      if (f3 == 3'b000) begin be = 4'b0001 << a[1:0]; wd = {4{sd[7:0]}}; end
      else if (f3 == 3'b001) begin be = 4'b0011 << a[1:0]; wd = {2{sd[15:0]}}; end
      else begin be = 4'b1111; wd = sd; end
    end
    sb.push_back(e);

    ex_valid = v; ex_reg_addr = ra; ex_control = c; ex_alu_result = a;
    ex_store_data = sd; ex_funct3 = f3; dmem_rdata = rd;
    done = 1'b0;
    nst = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      dmem_ack = (k == ackd);
      @(negedge clk);
      if (k == 0) begin
        chk({tag, "_req"}, 32'(dmem_req), 32'(req0));
        chk({tag, "_we"}, 32'(dmem_we), 32'(st && req0));
        chk({tag, "_be"}, 32'(dmem_be), 32'(be));
        chk({tag, "_wdata"}, dmem_wdata, wd);
        if (req0) chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
      end
      if (stall_o) begin
        nst++;
        chk({tag, "_bubble"}, {f_mem_control, 3'b000, f_mem_reg_addr, 16'h0} | f_mem_regdata
            | f_mem_memdata, 32'h0);
      end else begin
        done = 1'b1;
        got = sb.pop_front();
        chk({tag, "_rd"}, 32'(f_mem_reg_addr), 32'(got.ra));
        chk({tag, "_ctrl"}, 32'(f_mem_control), 32'(got.ctrl));
        chk({tag, "_memdata"}, f_mem_memdata, got.md);
        chk({tag, "_regdata"}, f_mem_regdata, got.rgd);
        chk({tag, "_stalls"}, 32'(nst), 32'(got.stalls));
        chk({tag, "_misalign"}, 32'(misalign_o), 32'(got.mis));
        chk({tag, "_buserr"}, 32'(bus_err_o), 32'(got.berr));
        chk({tag, "_req_end"}, 32'(dmem_req), 32'(got.req_done));
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      chk({tag, "_bound"}, 32'(done), 32'd1);
      void'(sb.pop_front());
    end
    dmem_ack = 1'b0;
    ex_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b1; ex_reg_addr = 5'd7; ex_control = 8'hAB; ex_alu_result = 32'h100;
    ex_store_data = 32'h0; ex_funct3 = 3'b010; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    #12;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_ctrl", 32'(f_mem_control), 32'd0);
    chk("rst_rd", 32'(f_mem_reg_addr), 32'd0);
    chk("rst_regdata", f_mem_regdata, 32'h0);
    chk("rst_memdata", f_mem_memdata, 32'h0);
    ex_valid = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_op("lw_fast",  1, 5'd1, 8'hAB, 32'h100, 32'h0,        3'b010, 0,  32'hDEADBEEF);
    do_op("lb_wait",  1, 5'd2, 8'hAB, 32'h103, 32'h0,        3'b000, 3,  32'h80FFFFFF);
    do_op("lbu_wait", 1, 5'd3, 8'hAB, 32'h103, 32'h0,        3'b100, 3,  32'h80FFFFFF);
    do_op("sh",       1, 5'd0, 8'h54, 32'h202, 32'h0000ABCD, 3'b001, 0,  32'h0);
    do_op("lw_mis",   1, 5'd4, 8'hAB, 32'h101, 32'h0,        3'b010, 0,  32'h0);
    do_op("sw_tmo",   1, 5'd0, 8'h54, 32'h400, 32'h11223344, 3'b010, -1, 32'h0);
    do_op("alu_post", 1, 5'd5, 8'h31, 32'h1234, 32'h0,       3'b000, -1, 32'h0);
    do_op("sw_ack_to",1, 5'd0, 8'h54, 32'h404, 32'h55667788, 3'b010, TO + 1, 32'h0);
    do_op("lh",       1, 5'd6, 8'hAB, 32'h102, 32'h0,        3'b001, 1,  32'h80010000);
    do_op("lhu",      1, 5'd6, 8'hAB, 32'h102, 32'h0,        3'b101, 2,  32'h80010000);
    do_op("sb",       1, 5'd0, 8'h54, 32'h101, 32'h12345678, 3'b000, 0,  32'h0);
    do_op("lunk",     1, 5'd8, 8'hAB, 32'h104, 32'h0,        3'b011, 0,  32'hCAFEF00D);
    do_op("lunk_mis", 1, 5'd8, 8'hAB, 32'h106, 32'h0,        3'b011, 0,  32'hCAFEF00D);
    do_op("rw_prio",  1, 5'd9, 8'h0F, 32'h001, 32'hFFFFFFFF, 3'b000, 1,  32'h00009A00);
    do_op("inval",    0, 5'd10, 8'hAB, 32'h200, 32'h0,       3'b010, 0,  32'h0);

    ex_valid = 1'b1; ex_reg_addr = 5'd11; ex_control = 8'hAB; ex_alu_result = 32'h300;
    ex_funct3 = 3'b010; dmem_ack = 1'b0;
    @(negedge clk);
    chk("rstw_stall_pre", 32'(stall_o), 32'd1);
    @(posedge clk);
    #1;
    chk("rstw_req_wait", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_req", 32'(dmem_req), 32'd0);
    chk("rstw_stall", 32'(stall_o), 32'd0);
    chk("rstw_ctrl", 32'(f_mem_control), 32'd0);
    chk("rstw_regdata", f_mem_regdata, 32'h0);
    chk("rstw_addr", dmem_addr, 32'h0);
    ex_valid = 1'b0;
    dmem_ack = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op("alu_stray", 1, 5'd12, 8'h31, 32'hA5A5_0001, 32'h0, 3'b010, 0, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have these ports: clk, input, 1, clock; all state rising-edge.
REQ-002 SHALL have rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have the following EX/MEM inputs: ex_valid 1; ex_reg_addr 5; ex_control 8; ex_alu_result 32 (address or ALU value); ex_store_data 32; ex_funct3 3.
REQ-004 SHALL have these MEM/WB outputs: f_mem_reg_addr 5; f_mem_control 8; f_mem_memdata 32; f_mem_regdata 32.
REQ-005 SHALL have these pipeline outputs: stall_o 1 (freeze PC, IF/ID, ID/EX, EX/MEM); misalign_o 1; bus_err_o 1 (one-cycle pulses).
REQ-006 SHALL have these data-bus ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32 (word-aligned, [1:0]=0); dmem_wdata out 32; dmem_be out 4; dmem_ack in 1; dmem_rdata in 32 (valid with ack).
REQ-007 SHALL use parameter TIMEOUT, default 255, as the maximum number of wait cycles before a bus error.

Function
REQ-008 SHALL decode the control bits as follows: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg; bits [7:4] pass through untouched.
REQ-009 SHALL classify an instruction as a memory op when ex_valid=1 and mem_read or mem_write=1; mem_read takes priority if both are set.
REQ-010 SHALL flag a misaligned access when LH/LHU/SH has addr[0]=1, or LW/SW has addr[1:0]!=0.
REQ-011 SHALL handle a misaligned op as follows: no dmem_req; misalign_o=1 for that cycle; f_mem_control forwarded with bits[2:0] cleared; no stall.
REQ-012 SHALL implement an FSM with states IDLE and WAIT.
REQ-013 SHALL, in IDLE with an aligned memory op, drive dmem_req=1 combinationally in the same cycle.
REQ-014 SHALL, if dmem_ack=1 in that same cycle, complete the op with zero stall and remain in IDLE.
REQ-015 SHALL, on no ack in IDLE, assert stall_o=1, move to WAIT, and clear the wait counter to 0.
REQ-016 SHALL, in WAIT, hold dmem_req=1 and all dmem_* outputs stable, since upstream holds its inputs stable via the stall.
REQ-017 SHALL, in WAIT on dmem_ack=1, complete the op, deassert stall_o that same cycle, and return to IDLE.
REQ-018 SHALL, in WAIT without ack, increment the wait counter.
REQ-019 SHALL abort when the counter reaches TIMEOUT without ack: bus_err_o=1 for one cycle; dmem_req drops; result forwarded with control bits[2:0] cleared; stall_o=0; return to IDLE.
REQ-020 SHALL treat an ack in the same cycle as the timeout as a normal completion.
REQ-021 SHALL, whenever stall_o=1, output f_mem_control=0, f_mem_reg_addr=0, f_mem_memdata=0 and f_mem_regdata=0 (bubble into MEM/WB).
REQ-022 SHALL, for a non-memory op or ex_valid=0, pass ex_reg_addr, ex_control and ex_alu_result→f_mem_regdata through combinationally, with f_mem_memdata=0 and zero latency.
REQ-023 SHALL drive f_mem_regdata = ex_alu_result for every non-stalled op.
REQ-024 SHALL drive f_mem_memdata as follows: on a load completion it is dmem_rdata shifted right by 8*addr[1:0], then LB/LH sign-extended from bit 7/15, LBU/LHU zero-extended, LW unchanged; otherwise 0.
REQ-025 SHALL generate store strobes as follows: SB be=0001<<addr[1:0] with wdata={4{byte}}; SH be=0011<<addr[1:0] with wdata={2{half}}; SW be=1111.
REQ-026 SHALL drive dmem_be=0000 for loads, and dmem_wdata=0, dmem_be=0, dmem_we=0 whenever dmem_req=0.
REQ-027 SHALL treat an unknown funct3 on a memory op as LW/SW.

Reset
REQ-028 SHALL, while rst_n=0, force state=IDLE, wait counter=0 and all outputs 0, asynchronously.
REQ-029 SHALL, on reset asserted in WAIT, drop dmem_req immediately and discard the pending access; a later stray ack in IDLE with no memory op is ignored.
REQ-030 SHALL leave reset deassertion synchronous to clk; the first op is accepted on the first edge after release.

Structure
REQ-031 SHALL place the control bit indices, funct3 codes (LB..SW), the FSM state type and the default TIMEOUT in shared package riscv_pkg.
REQ-032 SHALL implement the REQ-024 extraction in one combinational sub-module, load_align.
REQ-033 SHALL size the wait counter at $clog2(TIMEOUT+1) bits.

Verification
REQ-034 SHALL verify: LW addr 0x100, ack same cycle, rdata 0xDEADBEEF -> stall_o never 1, f_mem_memdata=0xDEADBEEF.
REQ-035 SHALL verify: LB addr 0x103, ack after 3 cycles, rdata 0x80FF_FFFF -> stall_o=1 for exactly 3 cycles, bubbles out, f_mem_memdata=0xFFFFFF80; LBU -> 0x00000080.
REQ-036 SHALL verify: SH addr 0x202, data 0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
REQ-037 SHALL verify: LW addr 0x101 -> misalign_o=1, dmem_req=0, f_mem_control[2:0]=000.
REQ-038 SHALL verify: SW with ack never asserted, TIMEOUT=4 -> bus_err_o pulse after 4 WAIT cycles, then stall_o=0 and state IDLE.
REQ-039 SHALL verify: rst_n low during WAIT -> dmem_req=0 immediately, all outputs 0; a following ALU op passes through unchanged.
